// File: rtl/regfile_wb_sched_if.sv
// Bus interface for regfile_wb_sched.
// It groups the issue handshake, the ALU and LSU writeback handshakes,
// the regfile write port and the status outputs.
//   master : the surrounding pipeline. It drives issue and writeback
//            requests, and it observes the readies, the write port and
//            the status outputs.
//   slave  : the scheduler.
interface regfile_wb_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // issue side
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rd_we;
  // ALU writeback
  logic              alu_wb_valid;
  logic              alu_wb_ready;
  logic [ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;
  // LSU writeback
  logic              lsu_wb_valid;
  logic              lsu_wb_ready;
  logic [ADDR_W-1:0] lsu_wb_addr;
  logic [DATA_W-1:0] lsu_wb_data;
  // regfile write port and status
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   busy_count;
  logic              err_spurious;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    input  iss_ready, alu_wb_ready, lsu_wb_ready,
    input  wr_enable, wr_addr, wr_data, busy_count, err_spurious
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    output iss_ready, alu_wb_ready, lsu_wb_ready,
    output wr_enable, wr_addr, wr_data, busy_count, err_spurious
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// This block sits on the issue side, next to the 32-entry register file.
//   - A busy bit is kept per destination register. Issue stalls on a
//     RAW or WAW hazard against a busy register.
//   - The single regfile write port is shared by ALU and LSU writeback.
//     A round-robin arbiter picks one source per cycle.
//   - The granted writeback passes through one registered output stage
//     (wr_enable/wr_addr/wr_data). The busy bit clears on the same edge
//     that the regfile commits the write.
// Ports:
//   clk   : clock. All state updates on the rising edge.
//   reset : synchronous, active-high.
//   bus   : regfile_wb_sched_if.slave. It carries:
//             - the issue handshake,
//             - the ALU and LSU writeback handshakes,
//             - the regfile write port,
//             - busy_count and err_spurious.
module regfile_wb_sched #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_sched_if.slave bus
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              last_grant_lsu;
  logic              hazard;
  logic              iss_fire;
  logic              grant_alu;
  logic              grant_lsu;
  logic              grant_any;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              grant_spurious;

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Issue: the hazard check uses only the registered busy bits.
  // busy[0] is never set, so x0 can never stall.
  always_comb begin
    hazard = busy[bus.iss_rs1] | busy[bus.iss_rs2] |
             (bus.iss_rd_we & busy[bus.iss_rd]);
    bus.iss_ready = !reset && !hazard;
    iss_fire = bus.iss_valid && bus.iss_ready;
  end

  // Round-robin arbitration. A tie goes to the source that did not win last.
  always_comb begin
    grant_alu = !reset && bus.alu_wb_valid &&
                (!bus.lsu_wb_valid || last_grant_lsu);
    grant_lsu = !reset && bus.lsu_wb_valid &&
                (!bus.alu_wb_valid || !last_grant_lsu);
    grant_any = grant_alu || grant_lsu;
    bus.alu_wb_ready = grant_alu;
    bus.lsu_wb_ready = grant_lsu;
    grant_addr = grant_lsu ? bus.lsu_wb_addr : bus.alu_wb_addr;
    grant_data = grant_lsu ? bus.lsu_wb_data : bus.alu_wb_data;
    // A writeback to a nonzero register that nobody is waiting on.
    grant_spurious = grant_any && (grant_addr != '0) && !busy[grant_addr];
  end

  // Next busy vector.
  // The clear is for the write that the regfile commits at this edge.
  // The set is for the issuing instruction. If both hit the same
  // register, the later producer owns it, so the set is applied last.
  always_comb begin
    busy_next = busy;
    if (bus.wr_enable) begin
      busy_next[bus.wr_addr] = 1'b0;
    end
    if (iss_fire && bus.iss_rd_we && (bus.iss_rd != '0)) begin
      busy_next[bus.iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Registered state and output stage. busy_count is registered from
  // busy_next, so it always matches the busy vector in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= '0;
      busy_count_reset();
    end else begin
      busy           <= busy_next;
      bus.busy_count <= popcount(busy_next);
      bus.err_spurious <= grant_spurious;
      if (grant_any) begin
        last_grant_lsu <= grant_lsu;
        bus.wr_addr    <= grant_addr;
        bus.wr_data    <= grant_data;
        bus.wr_enable  <= (grant_addr != '0);
      end else begin
        bus.wr_enable  <= 1'b0;
      end
    end
  end

  task automatic busy_count_reset();
    bus.busy_count   <= '0;
    bus.wr_enable    <= 1'b0;
    bus.wr_addr      <= '0;
    bus.wr_data      <= '0;
    bus.err_spurious <= 1'b0;
    // Reset leaves last_grant = LSU, so the ALU wins the first tie.
    last_grant_lsu   <= 1'b1;
  endtask

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  regfile_wb_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iss_valid    = 1'b0;
    bus.iss_rs1      = '0;
    bus.iss_rs2      = '0;
    bus.iss_rd       = '0;
    bus.iss_rd_we    = 1'b0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_addr  = '0;
    bus.alu_wb_data  = '0;
    bus.lsu_wb_valid = 1'b0;
    bus.lsu_wb_addr  = '0;
    bus.lsu_wb_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.iss_valid = 1'b1; bus.iss_rd = rd; bus.iss_rd_we = 1'b1;
    bus.iss_rs1 = '0; bus.iss_rs2 = '0;
    step();
    bus.iss_valid = 1'b0; bus.iss_rd_we = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    bus.iss_valid = 1'b1; bus.alu_wb_valid = 1'b1; bus.lsu_wb_valid = 1'b1;
    bus.alu_wb_addr = 5'd1; bus.lsu_wb_addr = 5'd2;
    step(); step();
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL rst_iss_ready got=%b exp=0", bus.iss_ready); end
    n_checks++; if (bus.alu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got=%b exp=0", bus.alu_wb_ready); end
    n_checks++; if (bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ready got=%b exp=0", bus.lsu_wb_ready); end
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL rst_wr_enable got=%b exp=0", bus.wr_enable); end
    clear_inputs();
    reset = 1'b0;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL idle_iss_ready got=%b exp=1", bus.iss_ready); end
    step();
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL idle_wr_enable got=%b exp=0", bus.wr_enable); end
    n_checks++; if (bus.wr_addr !== 5'd0) begin n_fail++; $display("FAIL idle_wr_addr got=%0d exp=0", bus.wr_addr); end
    n_checks++; if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL idle_wr_data got=%h exp=0", bus.wr_data); end
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL idle_busy_count got=%0d exp=0", bus.busy_count); end
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL idle_err got=%b exp=0", bus.err_spurious); end
  endtask

  task automatic test_raw();
    do_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.iss_rd_we = 1'b1;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got=%b exp=1", bus.iss_ready); end
    step();
    bus.iss_rd_we = 1'b0; bus.iss_rd = '0; bus.iss_rs1 = 5'd5;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got=%b exp=0", bus.iss_ready); end
    n_checks++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL raw_count1 got=%0d exp=1", bus.busy_count); end
    step();
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall2 got=%b exp=0", bus.iss_ready); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd5; bus.alu_wb_data = 32'h0000_1234;
    #1;
    n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL raw_alu_ready got=%b exp=1", bus.alu_wb_ready); end
    step();
    bus.alu_wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.wr_enable !== 1'b1) begin n_fail++; $display("FAIL raw_wr_enable got=%b exp=1", bus.wr_enable); end
    n_checks++; if (bus.wr_addr !== 5'd5) begin n_fail++; $display("FAIL raw_wr_addr got=%0d exp=5", bus.wr_addr); end
    n_checks++; if (bus.wr_data !== 32'h0000_1234) begin n_fail++; $display("FAIL raw_wr_data got=%h exp=00001234", bus.wr_data); end
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_during_wr got=%b exp=0", bus.iss_ready); end
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL raw_err got=%b exp=0", bus.err_spurious); end
    step();
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL raw_wr_enable_off got=%b exp=0", bus.wr_enable); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got=%b exp=1", bus.iss_ready); end
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL raw_count0 got=%0d exp=0", bus.busy_count); end
    step();
    clear_inputs();
  endtask

  task automatic test_dual_wb();
    do_reset();
    issue(5'd3);
    issue(5'd4);
    #1;
    n_checks++; if (bus.busy_count !== 6'd2) begin n_fail++; $display("FAIL dual_count2 got=%0d exp=2", bus.busy_count); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd3; bus.alu_wb_data = 32'hAAAA_0001;
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd4; bus.lsu_wb_data = 32'h5555_0002;
    #1;
    n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL dual_alu_first got=%b exp=1", bus.alu_wb_ready); end
    n_checks++; if (bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL dual_lsu_wait got=%b exp=0", bus.lsu_wb_ready); end
    step();
    bus.alu_wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd3) begin n_fail++; $display("FAIL dual_wr_x3 got=%b/%0d exp=1/3", bus.wr_enable, bus.wr_addr); end
    n_checks++; if (bus.wr_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL dual_data_x3 got=%h exp=aaaa0001", bus.wr_data); end
    n_checks++; if (bus.lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL dual_lsu_second got=%b exp=1", bus.lsu_wb_ready); end
    n_checks++; if (bus.busy_count !== 6'd2) begin n_fail++; $display("FAIL dual_count_hold got=%0d exp=2", bus.busy_count); end
    step();
    bus.lsu_wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd4) begin n_fail++; $display("FAIL dual_wr_x4 got=%b/%0d exp=1/4", bus.wr_enable, bus.wr_addr); end
    n_checks++; if (bus.wr_data !== 32'h5555_0002) begin n_fail++; $display("FAIL dual_data_x4 got=%h exp=55550002", bus.wr_data); end
    n_checks++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL dual_count1 got=%0d exp=1", bus.busy_count); end
    step();
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL dual_wr_idle got=%b exp=0", bus.wr_enable); end
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL dual_count0 got=%0d exp=0", bus.busy_count); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic       exp_alu;
    logic [4:0] exp_addr;
    do_reset();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd10; bus.alu_wb_data = 32'h0000_00A0;
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd11; bus.lsu_wb_data = 32'h0000_00B0;
    for (int i = 0; i < 4; i++) begin
      exp_alu  = (i % 2 == 0);
      exp_addr = exp_alu ? 5'd10 : 5'd11;
      #1;
      n_checks++; if (bus.alu_wb_ready !== exp_alu || bus.lsu_wb_ready !== !exp_alu) begin n_fail++; $display("FAIL rr_grant_%0d got alu=%b lsu=%b exp alu=%b", i, bus.alu_wb_ready, bus.lsu_wb_ready, exp_alu); end
      step();
      n_checks++; if (bus.wr_addr !== exp_addr || bus.wr_enable !== 1'b1) begin n_fail++; $display("FAIL rr_wr_%0d got=%0d/%b exp=%0d/1", i, bus.wr_addr, bus.wr_enable, exp_addr); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_spurious();
    do_reset();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd7; bus.alu_wb_data = 32'h0000_0077;
    #1;
    n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL spur_ready got=%b exp=1", bus.alu_wb_ready); end
    step();
    bus.alu_wb_valid = 1'b0;
    n_checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd7) begin n_fail++; $display("FAIL spur_write got=%b/%0d exp=1/7", bus.wr_enable, bus.wr_addr); end
    n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_pulse got=%b exp=1", bus.err_spurious); end
    step();
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_pulse_end got=%b exp=0", bus.err_spurious); end
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL spur_count got=%0d exp=0", bus.busy_count); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_addr = 5'd0; bus.alu_wb_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.alu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%b exp=1", bus.alu_wb_ready); end
    step();
    bus.alu_wb_valid = 1'b0;
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL x0_no_write got=%b exp=0", bus.wr_enable); end
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL x0_no_err got=%b exp=0", bus.err_spurious); end
    step();
    clear_inputs();
  endtask

  task automatic test_waw_x0();
    do_reset();
    issue(5'd9);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.iss_rd_we = 1'b1;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall got=%b exp=0", bus.iss_ready); end
    bus.iss_valid = 1'b0; bus.iss_rd_we = 1'b0;
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd9; bus.lsu_wb_data = 32'h0000_0099;
    step();
    bus.lsu_wb_valid = 1'b0;
    step();
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL waw_cleared got=%0d exp=0", bus.busy_count); end
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd0; bus.iss_rd = 5'd0; bus.iss_rd_we = 1'b1;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue_ready got=%b exp=1", bus.iss_ready); end
    step();
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL x0_not_busy got=%0d exp=0", bus.busy_count); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall got=%b exp=1", bus.iss_ready); end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(5'd2);
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_addr = 5'd2; bus.lsu_wb_data = 32'h0000_0022;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.lsu_wb_ready !== 1'b0 || bus.alu_wb_ready !== 1'b0 || bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_readies got=%b%b%b exp=000", bus.lsu_wb_ready, bus.alu_wb_ready, bus.iss_ready); end
    step();
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL mrst_no_write got=%b exp=0", bus.wr_enable); end
    reset = 1'b0;
    bus.lsu_wb_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd2;
    #1;
    n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL mrst_count got=%0d exp=0", bus.busy_count); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_issue got=%b exp=1", bus.iss_ready); end
    step();
    n_checks++; if (bus.wr_enable !== 1'b0) begin n_fail++; $display("FAIL mrst_wr_after got=%b exp=0", bus.wr_enable); end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_raw();
    test_dual_wb();
    test_back_to_back();
    test_spurious();
    test_waw_x0();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
